// File: rtl/matrix_uart_parser_if.sv
// Bundles the parser's control, UART RX/TX and storage-write signals.
// slave = parser side, master = menu FSM / UART / storage side.
interface matrix_uart_parser_if #(
  parameter int DATA_WIDTH = 9
);
  logic                       start;
  logic                       cancel;
  logic                       busy;
  logic                       done;
  logic                       err;
  logic [1:0]                 err_code;
  logic [7:0]                 rx_data;
  logic                       rx_valid;
  logic                       wr_en;
  logic [2:0]                 wr_row;
  logic [2:0]                 wr_col;
  logic [25*DATA_WIDTH-1:0]   wr_data;
  logic [7:0]                 tx_data;
  logic                       tx_start;
  logic                       tx_busy;

  modport slave (
    input  start, cancel, rx_data, rx_valid, tx_busy,
    output busy, done, err, err_code, wr_en, wr_row, wr_col, wr_data, tx_data, tx_start
  );

  modport master (
    output start, cancel, rx_data, rx_valid, tx_busy,
    input  busy, done, err, err_code, wr_en, wr_row, wr_col, wr_data, tx_data, tx_start
  );
endinterface

// File: rtl/matrix_uart_parser.sv
// Parses ASCII "rows cols e0 e1 ..." from UART RX into one matrix storage write.
// Optional byte echo to UART TX is enabled by defining MATRIX_PARSER_ECHO_EN.
module matrix_uart_parser #(
  parameter int DATA_WIDTH = 9,
  parameter int MAX_DIM    = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  matrix_uart_parser_if.slave  bus
);
  // Four spare bits let dimension tokens grow well past MAX_DIM before saturating.
  localparam int ACC_W   = DATA_WIDTH + 4;
  localparam int CACHE_W = 25 * DATA_WIDTH;
  localparam logic [ACC_W-1:0] ELEM_MAX = ACC_W'((1 << DATA_WIDTH) - 1);
  localparam logic [ACC_W-1:0] DIM_MAX  = ACC_W'(MAX_DIM);

  typedef enum logic [2:0] {S_IDLE, S_ROW, S_COL, S_ELEM, S_WRITE} state_t;

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= 8'h30) && (b <= 8'h39);
  endfunction

  function automatic logic is_sep(input logic [7:0] b);
    return (b == 8'h20) || (b == 8'h0D) || (b == 8'h0A) || (b == 8'h2C);
  endfunction

  // acc*10 + digit, saturating at all-ones instead of wrapping.
  function automatic logic [ACC_W-1:0] acc_step(input logic [ACC_W-1:0] a, input logic [7:0] b);
    logic [ACC_W+3:0] wide;
    wide = ({4'd0, a} * (ACC_W+4)'(10)) + (ACC_W+4)'(b[3:0]);
    if (wide > {4'd0, {ACC_W{1'b1}}}) return '1;
    return wide[ACC_W-1:0];
  endfunction

  state_t               state;
  logic [ACC_W-1:0]     acc;
  logic                 tok_active;
  logic [2:0]           row, col;
  logic [4:0]           elem_idx;
  logic [CACHE_W-1:0]   cache;
  logic                 busy, done, err, wr_en;
  logic [1:0]           err_code;

  logic [ACC_W-1:0]     acc_nxt;
  logic                 dim_ok, parsing, elem_last;
  logic [5:0]           total;
  logic [1:0]           fault;

  assign acc_nxt   = acc_step(acc, bus.rx_data);
  assign dim_ok    = (acc != '0) && (acc <= DIM_MAX);
  assign parsing   = (state == S_ROW) || (state == S_COL) || (state == S_ELEM);
  assign total     = {3'd0, row} * {3'd0, col};
  assign elem_last = ({1'b0, elem_idx} == (total - 6'd1));

  always_comb begin
    fault = 2'd0;
    if (parsing && bus.rx_valid) begin
      if (is_digit(bus.rx_data)) begin
        if ((state == S_ELEM) && (acc_nxt > ELEM_MAX)) fault = 2'd3;
      end else if (is_sep(bus.rx_data)) begin
        if (tok_active && (state != S_ELEM) && !dim_ok) fault = 2'd1;
      end else begin
        fault = 2'd2;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      acc        <= '0;
      tok_active <= 1'b0;
      row        <= '0;
      col        <= '0;
      elem_idx   <= '0;
      cache      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      wr_en      <= 1'b0;
      err_code   <= '0;
    end else begin
      done  <= 1'b0;
      err   <= 1'b0;
      wr_en <= 1'b0;
      if (bus.cancel && (state != S_IDLE)) begin
        state      <= S_IDLE;
        busy       <= 1'b0;
        acc        <= '0;
        tok_active <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (bus.start) begin
              cache      <= '0;
              err_code   <= '0;
              acc        <= '0;
              tok_active <= 1'b0;
              elem_idx   <= '0;
              busy       <= 1'b1;
              state      <= S_ROW;
            end
          end
          S_ROW, S_COL, S_ELEM: begin
            if (fault != 2'd0) begin
              err        <= 1'b1;
              err_code   <= fault;
              busy       <= 1'b0;
              acc        <= '0;
              tok_active <= 1'b0;
              state      <= S_IDLE;
            end else if (bus.rx_valid) begin
              if (is_digit(bus.rx_data)) begin
                acc        <= acc_nxt;
                tok_active <= 1'b1;
              end else if (tok_active) begin
                acc        <= '0;
                tok_active <= 1'b0;
                if (state == S_ROW) begin
                  row   <= acc[2:0];
                  state <= S_COL;
                end else if (state == S_COL) begin
                  col      <= acc[2:0];
                  elem_idx <= '0;
                  state    <= S_ELEM;
                end else begin
                  cache[int'(elem_idx)*DATA_WIDTH +: DATA_WIDTH] <= acc[DATA_WIDTH-1:0];
                  if (elem_last) begin
                    wr_en <= 1'b1;
                    done  <= 1'b1;
                    state <= S_WRITE;
                  end else begin
                    elem_idx <= elem_idx + 5'd1;
                  end
                end
              end
            end
          end
          S_WRITE: begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.busy     = busy;
  assign bus.done     = done;
  assign bus.err      = err;
  assign bus.err_code = err_code;
  assign bus.wr_en    = wr_en;
  assign bus.wr_row   = row;
  assign bus.wr_col   = col;
  assign bus.wr_data  = cache;

`ifdef MATRIX_PARSER_ECHO_EN
  // Echo requests are dropped, never queued, while a previous echo is pending.
  logic [7:0] tx_data_q;
  logic       tx_start_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
    end else if (tx_start_q) begin
      if (!bus.tx_busy) tx_start_q <= 1'b0;
    end else if (bus.rx_valid && busy && !bus.tx_busy) begin
      tx_start_q <= 1'b1;
      tx_data_q  <= bus.rx_data;
    end
  end

  assign bus.tx_data  = tx_data_q;
  assign bus.tx_start = tx_start_q;
`else
  logic unused_tx_busy;
  assign unused_tx_busy = bus.tx_busy;
  assign bus.tx_data    = '0;
  assign bus.tx_start   = 1'b0;
`endif
endmodule

// File: tb/tb_matrix_uart_parser.sv
// Directed bench for matrix_uart_parser: dimensions, elements, errors, cancel, echo.
module tb_matrix_uart_parser;
  localparam int DW = 9;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   wr_cnt = 0, done_cnt = 0, err_cnt = 0;

  matrix_uart_parser_if #(.DATA_WIDTH(DW)) bus();
  matrix_uart_parser #(.DATA_WIDTH(DW), .MAX_DIM(5)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.wr_en) wr_cnt++;
    if (bus.done)  done_cnt++;
    if (bus.err)   err_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    tick();
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    int w0;
    bus.start = 0; bus.cancel = 0; bus.rx_data = 0; bus.rx_valid = 0; bus.tx_busy = 0;
    rst_n = 1'b0;
    repeat (3) tick();
    total++; if ({bus.busy, bus.done, bus.err, bus.wr_en, bus.tx_start} !== 5'b0) begin bad++; $display("FAIL reset_flags: got %b want 00000", {bus.busy, bus.done, bus.err, bus.wr_en, bus.tx_start}); end
    total++; if ({bus.err_code, bus.wr_row, bus.wr_col, bus.tx_data} !== 16'h0) begin bad++; $display("FAIL reset_fields: got %h want 0", {bus.err_code, bus.wr_row, bus.wr_col, bus.tx_data}); end
    total++; if (bus.wr_data !== '0) begin bad++; $display("FAIL reset_wr_data: got %h want 0", bus.wr_data); end
    rst_n = 1'b1;
    tick();
    w0 = wr_cnt;
    send_str("1 1 7 ");
    tick();
    total++; if (bus.busy !== 1'b0 || wr_cnt != w0) begin bad++; $display("FAIL idle_ignores_rx: busy=%b wr=%0d want busy=0 wr=0", bus.busy, wr_cnt - w0); end
  endtask

  task automatic test_basic();
    logic [25*DW-1:0] exp;
    int w0, e0;
    exp = '0;
    for (int k = 0; k < 6; k++) exp[k*DW +: DW] = DW'(k + 1);
    w0 = wr_cnt; e0 = err_cnt;
    pulse_start();
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL basic_busy_after_start: got %b want 1", bus.busy); end
    send_str("2 3 1 2 3 4 5 6");
    total++; if (bus.wr_en !== 1'b0) begin bad++; $display("FAIL basic_unterminated: wr_en=%b want 0", bus.wr_en); end
    send_byte(8'h0A);
    total++; if (bus.wr_en !== 1'b1 || bus.done !== 1'b1 || bus.busy !== 1'b1) begin bad++; $display("FAIL basic_write_pulse: wr_en=%b done=%b busy=%b want 1 1 1", bus.wr_en, bus.done, bus.busy); end
    total++; if (bus.wr_row !== 3'd2 || bus.wr_col !== 3'd3) begin bad++; $display("FAIL basic_dims: got %0d x %0d want 2 x 3", bus.wr_row, bus.wr_col); end
    total++; if (bus.wr_data !== exp) begin bad++; $display("FAIL basic_data: got %h want %h", bus.wr_data, exp); end
    tick();
    total++; if (bus.wr_en !== 1'b0 || bus.done !== 1'b0 || bus.busy !== 1'b0) begin bad++; $display("FAIL basic_after_write: wr_en=%b done=%b busy=%b want 0 0 0", bus.wr_en, bus.done, bus.busy); end
    tick();
    total++; if (bus.wr_data !== exp || wr_cnt - w0 != 1 || err_cnt != e0) begin bad++; $display("FAIL basic_hold_count: wr=%0d err=%0d held=%b want 1 0 1", wr_cnt - w0, err_cnt - e0, bus.wr_data === exp); end
  endtask

  task automatic test_bad_dim();
    int w0;
    w0 = wr_cnt;
    pulse_start();
    send_str("6");
    send_byte(" ");
    total++; if (bus.err !== 1'b1 || bus.err_code !== 2'd1 || bus.busy !== 1'b0) begin bad++; $display("FAIL dim_too_big: err=%b code=%0d busy=%b want 1 1 0", bus.err, bus.err_code, bus.busy); end
    tick();
    total++; if (bus.err !== 1'b0 || bus.err_code !== 2'd1) begin bad++; $display("FAIL dim_code_hold: err=%b code=%0d want 0 1", bus.err, bus.err_code); end
    pulse_start();
    total++; if (bus.err_code !== 2'd0) begin bad++; $display("FAIL start_clears_code: got %0d want 0", bus.err_code); end
    send_str("2 0");
    send_byte(",");
    total++; if (bus.err !== 1'b1 || bus.err_code !== 2'd1) begin bad++; $display("FAIL dim_zero_col: err=%b code=%0d want 1 1", bus.err, bus.err_code); end
    tick();
    total++; if (wr_cnt != w0) begin bad++; $display("FAIL dim_no_write: got %0d want 0", wr_cnt - w0); end
  endtask

  task automatic test_overflow();
    logic [25*DW-1:0] exp;
    int w0;
    w0 = wr_cnt;
    pulse_start();
    send_str("1 1 51");
    send_byte("2");
    total++; if (bus.err !== 1'b1 || bus.err_code !== 2'd3 || bus.busy !== 1'b0) begin bad++; $display("FAIL elem_overflow: err=%b code=%0d busy=%b want 1 3 0", bus.err, bus.err_code, bus.busy); end
    tick();
    total++; if (wr_cnt != w0) begin bad++; $display("FAIL overflow_no_write: got %0d want 0", wr_cnt - w0); end
    exp = '0;
    exp[DW-1:0] = 9'd511;
    pulse_start();
    send_str("1 1 511");
    send_byte(" ");
    total++; if (bus.wr_en !== 1'b1 || bus.wr_data !== exp) begin bad++; $display("FAIL elem_max: wr_en=%b data=%h want 1 %h", bus.wr_en, bus.wr_data, exp); end
    tick();
  endtask

  task automatic test_illegal();
    int w0;
    w0 = wr_cnt;
    pulse_start();
    send_str("2,,  2\r\n7 ");
    total++; if (bus.busy !== 1'b1 || bus.err !== 1'b0) begin bad++; $display("FAIL seps_tolerated: busy=%b err=%b want 1 0", bus.busy, bus.err); end
    send_byte("x");
    total++; if (bus.err !== 1'b1 || bus.err_code !== 2'd2 || bus.busy !== 1'b0) begin bad++; $display("FAIL illegal_char: err=%b code=%0d busy=%b want 1 2 0", bus.err, bus.err_code, bus.busy); end
    tick();
    total++; if (wr_cnt != w0) begin bad++; $display("FAIL illegal_no_write: got %0d want 0", wr_cnt - w0); end
  endtask

  task automatic test_cancel();
    logic [25*DW-1:0] exp;
    int w0, e0, d0;
    w0 = wr_cnt; e0 = err_cnt; d0 = done_cnt;
    pulse_start();
    send_str("3 3 1 2 ");
    bus.rx_data = "x"; bus.rx_valid = 1'b1; bus.cancel = 1'b1;
    tick();
    bus.rx_valid = 1'b0; bus.cancel = 1'b0;
    total++; if (bus.busy !== 1'b0 || bus.err !== 1'b0 || bus.done !== 1'b0 || bus.wr_en !== 1'b0) begin bad++; $display("FAIL cancel_state: busy=%b err=%b done=%b wr=%b want 0 0 0 0", bus.busy, bus.err, bus.done, bus.wr_en); end
    tick();
    total++; if (wr_cnt != w0 || err_cnt != e0 || done_cnt != d0) begin bad++; $display("FAIL cancel_pulses: wr=%0d err=%0d done=%0d want 0 0 0", wr_cnt - w0, err_cnt - e0, done_cnt - d0); end
    exp = '0;
    exp[DW-1:0] = 9'd9;
    pulse_start();
    send_str("1 1 9");
    send_byte(" ");
    total++; if (bus.wr_en !== 1'b1 || bus.wr_row !== 3'd1 || bus.wr_col !== 3'd1 || bus.wr_data !== exp) begin bad++; $display("FAIL after_cancel_write: wr=%b dims=%0dx%0d data=%h want 1 1x1 %h", bus.wr_en, bus.wr_row, bus.wr_col, bus.wr_data, exp); end
    tick();
  endtask

  task automatic test_start_while_busy();
    logic [25*DW-1:0] exp;
    exp = '0;
    for (int k = 0; k < 4; k++) exp[k*DW +: DW] = DW'(k + 5);
    pulse_start();
    send_str("2 ");
    pulse_start();
    send_str("2 5 6 7 8");
    send_byte(" ");
    total++; if (bus.wr_en !== 1'b1 || bus.wr_row !== 3'd2 || bus.wr_col !== 3'd2 || bus.wr_data !== exp) begin bad++; $display("FAIL start_while_busy: wr=%b dims=%0dx%0d data=%h want 1 2x2 %h", bus.wr_en, bus.wr_row, bus.wr_col, bus.wr_data, exp); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [25*DW-1:0] exp;
    exp = '0;
    for (int k = 0; k < 25; k++) exp[k*DW +: DW] = DW'(k * 20);
    pulse_start();
    send_str("5 5 ");
    for (int k = 0; k < 24; k++) send_str($sformatf("%0d ", k * 20));
    send_str("480");
    send_byte("\n");
    total++; if (bus.wr_en !== 1'b1 || bus.wr_row !== 3'd5 || bus.wr_col !== 3'd5 || bus.wr_data !== exp) begin bad++; $display("FAIL full_5x5: wr=%b dims=%0dx%0d data=%h want 1 5x5 %h", bus.wr_en, bus.wr_row, bus.wr_col, bus.wr_data, exp); end
    tick();
    exp = '0;
    exp[DW-1:0] = 9'd3;
    pulse_start();
    send_str("1,1,3");
    send_byte(",");
    total++; if (bus.wr_en !== 1'b1 || bus.wr_data !== exp) begin bad++; $display("FAIL back_to_back: wr=%b data=%h want 1 %h", bus.wr_en, bus.wr_data, exp); end
    tick();
  endtask

  task automatic test_echo();
    pulse_start();
    bus.tx_busy = 1'b0;
    send_byte("3");
`ifdef MATRIX_PARSER_ECHO_EN
    total++; if (bus.tx_start !== 1'b1 || bus.tx_data !== 8'h33) begin bad++; $display("FAIL echo_byte: start=%b data=%h want 1 33", bus.tx_start, bus.tx_data); end
    tick();
    total++; if (bus.tx_start !== 1'b0) begin bad++; $display("FAIL echo_clear: got %b want 0", bus.tx_start); end
    bus.tx_busy = 1'b1;
    send_byte(",");
    total++; if (bus.tx_start !== 1'b0) begin bad++; $display("FAIL echo_dropped_busy: got %b want 0", bus.tx_start); end
    bus.tx_busy = 1'b0;
`else
    total++; if (bus.tx_start !== 1'b0 || bus.tx_data !== 8'h00) begin bad++; $display("FAIL echo_disabled: start=%b data=%h want 0 00", bus.tx_start, bus.tx_data); end
`endif
    bus.cancel = 1'b1;
    tick();
    bus.cancel = 1'b0;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL echo_cleanup: busy=%b want 0", bus.busy); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bad_dim();
    test_overflow();
    test_illegal();
    test_cancel();
    test_start_while_busy();
    test_back_to_back();
    test_echo();
    repeat (2) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
